ysyx_25040101_ifu: RTL

Instruction fetch unit that sits directly upstream of the single-cycle core datapath. It owns the fetch PC and issues word fetches to instruction memory over a valid/ready request channel. It accepts variable-latency responses and buffers fetched instructions in a small FIFO. It presents them to decode with a valid/ready handshake, and handles PC redirects from the core by flushing the buffer and discarding any stale in-flight response.

---
 rtl/ysyx_25040101_pkg.sv | 17 +
 rtl/ysyx_25040101_ifu_fifo.sv | 58 +++++
 rtl/ysyx_25040101_ifu.sv | 98 +++++++++
 3 files changed

// File: rtl/ysyx_25040101_pkg.sv
// Shared constants for the fetch unit: reset PC, instruction width, FSM encoding
// and the {pc, inst} record carried through the instruction buffer.
package ysyx_25040101_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam int          INST_W           = 32;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_t;

endpackage

// File: rtl/ysyx_25040101_ifu_fifo.sv
// DEPTH-entry instruction buffer of {pc, inst}; head is visible the cycle after push.
// Flush beats push and pop; a pop on empty is ignored, a push on full only lands with a pop.
module ysyx_25040101_ifu_fifo
    import ysyx_25040101_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_t        push_dat,
    input  logic          pop,
    input  logic          flush,
    output fetch_t        head_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_25040101_ifu.sv
// Fetch unit: one outstanding word fetch, buffered results to decode, redirect flush.
// Outputs are registered; response at N is visible at N+1; no request while buffer is full.
module ysyx_25040101_ifu
    import ysyx_25040101_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [31:0]       req_addr,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          req_hs;
    logic          push;
    logic          pop;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    fetch_t        head;

    assign req_hs = req_valid && req_ready;
    // A redirect voids any pop and any push in its cycle; the buffer is flushed instead.
    assign pop    = inst_valid && inst_ready && !redirect_valid;
    assign push   = (state == S_WAIT) && rsp_valid && !redirect_valid && !buf_full;

    assign count_nxt = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ:   if (req_hs) state_nxt = redirect_valid ? S_DROP : S_WAIT;
            S_WAIT:  if (rsp_valid) state_nxt = S_REQ;
                     else if (redirect_valid) state_nxt = S_DROP;
            S_DROP:  if (rsp_valid) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    // req_valid is precomputed from next state/occupancy so it stays a plain register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            req_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_valid <= (state_nxt == S_REQ) && (count_nxt < CW'(BUF_DEPTH));
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (req_hs) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (req_hs) begin
                req_pc <= fetch_pc;
            end
        end
    end

    ysyx_25040101_ifu_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ('{pc: req_pc, inst: rsp_data}),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (count)
    );

    assign req_addr   = fetch_pc;
    assign inst_valid = !buf_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule
